// File: rtl/asyn_dff_pipe.sv
// asyn_dff_pipe: elastic valid/ready delay line of DEPTH async-reset register stages with bubble collapse.
// Latency: a word accepted at edge N into an empty pipe shows on out_* after edge N+DEPTH-1; 1 word/cycle sustained.
// Backpressure: empty stages always accept, so in_ready drops only when every stage is full and out_ready=0.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   clr                     synchronous flush: empties every stage and reloads RESET_VAL
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (last stage)
//   count                   number of occupied stages, 0..DEPTH
module asyn_dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] mv;
    logic [WIDTH-1:0] dat [DEPTH];

    logic in_fire;
    logic out_fire;

    // A stage moves when it is empty or the stage below it moves. Unrolled,
    // stage k is blocked only when stages k..DEPTH-1 are all full and the
    // output is stalled, so a running AND from the output end gives every
    // enable without a self-referencing chain.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        mv       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            all_full = all_full & vld[k];
            mv[k]    = !all_full | out_ready;
        end
    end

    // Combinational out_ready -> in_ready path is intentional: a full pipe
    // still accepts a word in the same cycle the output drains one.
    assign in_ready  = mv[0] & !clr;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    genvar k;
    for (k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;
        logic             s_vld;
        logic [WIDTH-1:0] s_dat;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_dat = in_data;
        end else begin : g_body
            assign up_vld = vld[k-1];
            assign up_dat = dat[k-1];
        end

        // Payload only loads behind a valid bit; an empty stage keeps stale
        // data to avoid toggling the wide register for nothing.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_vld <= 1'b0;
                s_dat <= RESET_VAL;
            end else if (clr) begin
                s_vld <= 1'b0;
                s_dat <= RESET_VAL;
            end else if (mv[k]) begin
                s_vld <= up_vld;
                if (up_vld) begin
                    s_dat <= up_dat;
                end
            end
        end

        assign vld[k] = s_vld;
        assign dat[k] = s_dat;
    end

    // Occupancy tracks fires rather than recounting vld each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (in_fire && !out_fire) begin
            count <= count + CW'(1);
        end else if (out_fire && !in_fire) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: doc/asyn_dff_pipe.md
# asyn_dff_pipe

Parametrised elastic register pipeline built from asynchronous-reset flip-flops. It carries a WIDTH-bit payload through DEPTH register stages under a valid/ready handshake, and collapses bubbles so a stalled output lets upstream stages keep filling. It generalises the single async-reset DFF into a flushable, back-pressurable delay line with an occupancy count, for use between datapath blocks that need registered boundaries.

## Interface
- WIDTH, 8, payload width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RESET_VAL, 0, value loaded into every data stage on reset or clear (WIDTH bits)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- clr  input  1  synchronous flush, active-high
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipeline can accept in_data this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  WIDTH  payload of stage DEPTH-1
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

## Operation
- Stage k (0..DEPTH-1) holds vld[k] and dat[k]. Stage 0 is the input, stage DEPTH-1 is the output. out_valid = vld[DEPTH-1], out_data = dat[DEPTH-1].
- Stage move enable: mv[DEPTH-1] = !vld[DEPTH-1] | out_ready; mv[k] = !vld[k] | mv[k+1]. in_ready = mv[0] & !clr. The path from out_ready to in_ready is combinational by design.
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- On each rising edge with clr=0, every stage with mv[k]=1 loads from its upstream stage: stage 0 loads vld=in_valid and dat=in_data; stage k>0 loads vld[k-1] and dat[k-1]. Stages with mv[k]=0 hold.
- dat[k] loads only when the incoming vld is 1. An empty stage keeps its old data, which saves power, and that data is don't-care.
- Bubble collapse: an empty stage always accepts, so while out_ready=0 the pipe fills until all DEPTH stages are valid. in_ready=0 only when all stages are valid and out_ready=0.
- count: +1 on in_fire only, -1 on out_fire only, unchanged when both or neither fire. count always equals the popcount of vld.
- clr=1 at an edge: all vld become 0, all dat become RESET_VAL, and count becomes 0. in_ready=0 while clr is high. Input presented during clr is not accepted. An out_fire in the clr cycle still completes, because out_data is valid during that cycle.
- rst_n=0: asynchronously, without waiting for clk, all vld become 0, all dat become RESET_VAL, and count becomes 0. The state holds while rst_n is low.

## Timing
- Reset values: out_valid=0, out_data=RESET_VAL, count=0, in_ready=1 once rst_n=1 and clr=0.
- rst_n assertion takes effect immediately, mid-cycle, even during a transfer. Deassertion is synchronous to the next rising edge, and the first accepted word is the one present at that edge.
- Latency with the pipe empty and out_ready=1: a word accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, and is first sampleable at edge N+DEPTH.
- Throughput is 1 word per cycle sustained when out_ready=1.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Data order is strictly FIFO. No drop or duplication occurs outside clr or reset.
- DEPTH=1 degenerates to a single handshaked register with the same rules.

## Test plan
- Reset mid-stream: WIDTH=8, DEPTH=4, RESET_VAL=8'h5A. Stream 0x01..0x03, then pull rst_n low 3 ns after an edge. Required: out_valid=0, out_data=0x5A and count=0 within the same cycle. After release the first output is the next word sent.
- Latency and throughput: with out_ready=1, send 0x10..0x17 on consecutive cycles. Required: 0x10 sampled at edge 4 after its accept edge, then one word per cycle in order, count steady at 4 mid-stream.
- Backpressure fill: with out_ready=0, send 0xA0..0xA5. Required: 0xA0..0xA3 accepted, in_ready=0 after the 4th, count=4, out_data held at 0xA0. Raise out_ready and 0xA0..0xA5 emerge in order.
- Simultaneous fire: full pipe with in_valid=1 and out_ready=1 for 10 cycles. Required: count stays 4 and in_ready stays 1 via the combinational path.
- Clear: pipe holding 3 words, assert clr for one cycle with in_valid=1 and in_data=0xFF. Required: 0xFF not accepted, count=0, out_valid=0 and out_data=0x5A at the next edge.
- Bubbles: alternate in_valid 1/0 with out_ready toggling randomly for 200 cycles against a scoreboard. Required: no loss, no duplication, order preserved, and count matches the scoreboard every cycle.
